// File: rtl/apu_envelope_length.sv
// Volume envelope and length counter for one APU pulse/noise channel.
// Optional macro APU_LENGTH_MUTE_EN forces volume to 0 while the length counter is 0.
module apu_envelope_length (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       cpu_clk_en,
  input  logic       quarter_clk_en,
  input  logic       half_clk_en,
  input  logic       ctrl_wr,
  input  logic [5:0] ctrl_data,
  input  logic       len_wr,
  input  logic [4:0] len_idx,
  input  logic       chan_en,
  output logic [3:0] volume,
  output logic       length_active
);

  logic       halt_q,       halt_d;
  logic       const_vol_q,  const_vol_d;
  logic [3:0] period_q,     period_d;
  logic       start_flag_q, start_flag_d;
  logic [3:0] divider_q,    divider_d;
  logic [3:0] decay_q,      decay_d;
  logic [7:0] length_cnt_q, length_cnt_d;

  logic qtick, htick, ctrl_we, len_we;

  function automatic logic [7:0] length_lookup(input logic [4:0] idx);
    logic [7:0] val;
    case (idx)
      5'd0:  val = 8'd10;   5'd1:  val = 8'd254;  5'd2:  val = 8'd20;   5'd3:  val = 8'd2;
      5'd4:  val = 8'd40;   5'd5:  val = 8'd4;    5'd6:  val = 8'd80;   5'd7:  val = 8'd6;
      5'd8:  val = 8'd160;  5'd9:  val = 8'd8;    5'd10: val = 8'd60;   5'd11: val = 8'd10;
      5'd12: val = 8'd14;   5'd13: val = 8'd12;   5'd14: val = 8'd26;   5'd15: val = 8'd14;
      5'd16: val = 8'd12;   5'd17: val = 8'd16;   5'd18: val = 8'd24;   5'd19: val = 8'd18;
      5'd20: val = 8'd48;   5'd21: val = 8'd20;   5'd22: val = 8'd96;   5'd23: val = 8'd22;
      5'd24: val = 8'd192;  5'd25: val = 8'd24;   5'd26: val = 8'd72;   5'd27: val = 8'd26;
      5'd28: val = 8'd16;   5'd29: val = 8'd28;   5'd30: val = 8'd32;   default: val = 8'd30;
    endcase
    return val;
  endfunction

  // Strobes may be held for several clk cycles; gating by cpu_clk_en makes each count once.
  assign qtick   = quarter_clk_en & cpu_clk_en;
  assign htick   = half_clk_en & cpu_clk_en;
  assign ctrl_we = ctrl_wr & cpu_clk_en;
  assign len_we  = len_wr & cpu_clk_en;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    halt_d       = halt_q;
    const_vol_d  = const_vol_q;
    period_d     = period_q;
    start_flag_d = start_flag_q;
    divider_d    = divider_q;
    decay_d      = decay_q;
    length_cnt_d = length_cnt_q;

    // Envelope sees the old control values and the old start flag.
    if (qtick) begin
      if (start_flag_q) begin
        start_flag_d = 1'b0;
        decay_d      = 4'd15;
        divider_d    = period_q;
      end else if (divider_q == 4'd0) begin
        divider_d = period_q;
        if (decay_q != 4'd0) decay_d = decay_q - 4'd1;
        else if (halt_q)     decay_d = 4'd15;
      end else begin
        divider_d = divider_q - 4'd1;
      end
    end

    if (len_we) start_flag_d = 1'b1;

    if (ctrl_we) begin
      halt_d      = ctrl_data[5];
      const_vol_d = ctrl_data[4];
      period_d    = ctrl_data[3:0];
    end

    // Disable wins over load, load wins over decrement.
    if (!chan_en)
      length_cnt_d = 8'd0;
    else if (len_we)
      length_cnt_d = length_lookup(len_idx);
    else if (htick && !halt_q && length_cnt_q != 8'd0)
      length_cnt_d = length_cnt_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_l) begin
      halt_q       <= 1'b0;
      const_vol_q  <= 1'b0;
      period_q     <= 4'd0;
      start_flag_q <= 1'b0;
      divider_q    <= 4'd0;
      decay_q      <= 4'd0;
      length_cnt_q <= 8'd0;
    end else begin
      halt_q       <= halt_d;
      const_vol_q  <= const_vol_d;
      period_q     <= period_d;
      start_flag_q <= start_flag_d;
      divider_q    <= divider_d;
      decay_q      <= decay_d;
      length_cnt_q <= length_cnt_d;
    end
  end

  assign length_active = (length_cnt_q != 8'd0);

  // The counter is already forced to 0 while the channel is disabled, so muting on
  // length_cnt alone covers chan_en without an input-to-output path.
`ifdef APU_LENGTH_MUTE_EN
  assign volume = (length_cnt_q == 8'd0) ? 4'd0 : (const_vol_q ? period_q : decay_q);
`else
  assign volume = const_vol_q ? period_q : decay_q;
`endif

endmodule

// File: tb/tb_apu_envelope_length.sv
// Self-checking bench for apu_envelope_length: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_apu_envelope_length;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       cpu_clk_en = 1'b1;
  logic       quarter_clk_en = 1'b0;
  logic       half_clk_en = 1'b0;
  logic       ctrl_wr = 1'b0;
  logic [5:0] ctrl_data = 6'd0;
  logic       len_wr = 1'b0;
  logic [4:0] len_idx = 5'd0;
  logic       chan_en = 1'b1;
  logic [3:0] volume;
  logic       length_active;

  int checks = 0;
  int errors = 0;

  apu_envelope_length dut (
    .clk(clk), .rst_l(rst_l), .cpu_clk_en(cpu_clk_en),
    .quarter_clk_en(quarter_clk_en), .half_clk_en(half_clk_en),
    .ctrl_wr(ctrl_wr), .ctrl_data(ctrl_data), .len_wr(len_wr), .len_idx(len_idx),
    .chan_en(chan_en), .volume(volume), .length_active(length_active)
  );

  always #5 clk = ~clk;

  // Behavioural reference state, kept as plain integers.
  int len_table [32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                         12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};
  int  m_len, m_decay, m_div, m_period;
  bit  m_halt, m_cv, m_start;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_volume();
    int v = m_cv ? m_period : m_decay;
`ifdef APU_LENGTH_MUTE_EN
    if (m_len == 0) v = 0;
`endif
    return v;
  endfunction

  // Advance the model by one clk edge using the inputs present at that edge.
  task automatic model_step();
    bit q = quarter_clk_en && cpu_clk_en;
    bit h = half_clk_en && cpu_clk_en;
    bit wc = ctrl_wr && cpu_clk_en;
    bit wl = len_wr && cpu_clk_en;
    int next_len = m_len;
    if (!rst_l) begin
      m_len = 0; m_decay = 0; m_div = 0; m_period = 0;
      m_halt = 0; m_cv = 0; m_start = 0;
      return;
    end
    if (!chan_en)                   next_len = 0;
    else if (wl)                    next_len = len_table[len_idx];
    else if (h && !m_halt && m_len > 0) next_len = m_len - 1;
    if (q) begin
      if (m_start) begin
        m_start = 0; m_decay = 15; m_div = m_period;
      end else if (m_div == 0) begin
        m_div = m_period;
        if (m_decay > 0) m_decay = m_decay - 1;
        else if (m_halt) m_decay = 15;
      end else begin
        m_div = m_div - 1;
      end
    end
    if (wl) m_start = 1;
    if (wc) begin
      m_halt = ctrl_data[5]; m_cv = ctrl_data[4]; m_period = int'(ctrl_data[3:0]);
    end
    m_len = next_len;
  endtask

  // One clock: edge, model update, sample 1 time unit later, then clear one-shot strobes.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model_volume", int'(volume), model_volume());
    check("model_length_active", int'(length_active), int'(m_len != 0));
    check("model_length_cnt", int'(dut.length_cnt_q), m_len);
    quarter_clk_en = 1'b0;
    half_clk_en    = 1'b0;
    ctrl_wr        = 1'b0;
    len_wr         = 1'b0;
  endtask

  task automatic write_ctrl(input logic [5:0] d);
    ctrl_wr = 1'b1; ctrl_data = d; cycle();
  endtask

  task automatic write_len(input logic [4:0] idx);
    len_wr = 1'b1; len_idx = idx; cycle();
  endtask

  task automatic qtick_n(input int n);
    for (int i = 0; i < n; i++) begin quarter_clk_en = 1'b1; cycle(); end
  endtask

  initial begin
    m_len = 0; m_decay = 0; m_div = 0; m_period = 0; m_halt = 0; m_cv = 0; m_start = 0;

    // Reset state.
    rst_l = 1'b0; cycle(); cycle();
    check("reset_volume", int'(volume), 0);
    check("reset_length_active", int'(length_active), 0);
    rst_l = 1'b1;

    // Envelope with period 3: starts at 15, decrements every 4 qticks, holds at 0.
    chan_en = 1'b1;
    write_ctrl(6'b000011);
    write_len(5'd1);
    qtick_n(1);
    check("env_start_15", int'(volume), 15);
    check("env_len_active", int'(length_active), 1);
    qtick_n(4);
    check("env_after_4q", int'(volume), 14);
    qtick_n(56);
    check("env_reaches_0", int'(volume), 0);
    qtick_n(8);
    check("env_holds_0", int'(volume), 0);

    // Loop mode, period 0: 15..0 then wraps to 15; halt freezes the length counter.
    write_ctrl(6'b100000);
    write_len(5'd1);
    qtick_n(1);
    for (int k = 1; k <= 15; k++) begin
      qtick_n(1);
      check("loop_step", int'(volume), 15 - k);
    end
    qtick_n(1);
    check("loop_wrap_15", int'(volume), 15);
    half_clk_en = 1'b1; cycle();
    check("halt_len_frozen", int'(dut.length_cnt_q), 254);

    // Length 2 with halt clear: length_active falls after the second htick.
    write_ctrl(6'b000000);
    write_len(5'd3);
    half_clk_en = 1'b1; cycle();
    check("len_after_1h", int'(length_active), 1);
    half_clk_en = 1'b1; cycle();
    check("len_after_2h", int'(length_active), 0);

    // Quarter strobe held 5 clks with one cpu enable: exactly one envelope step.
    write_len(5'd1);
    qtick_n(1);
    check("held_pre", int'(volume), 15);
    for (int i = 0; i < 5; i++) begin
      quarter_clk_en = 1'b1; cpu_clk_en = (i == 2); cycle();
    end
    cpu_clk_en = 1'b1;
    check("held_one_step", int'(volume), 14);

    // Channel disable clears length; a load while disabled still arms the envelope.
    write_len(5'd0);
    check("len_load_10", int'(dut.length_cnt_q), 10);
    qtick_n(2);
    check("pre_disable_vol", int'(volume), 14);
    chan_en = 1'b0; cycle();
    check("disable_clears", int'(dut.length_cnt_q), 0);
    write_len(5'd8);
    check("load_while_disabled", int'(dut.length_cnt_q), 0);
    chan_en = 1'b1;
    qtick_n(1);
    check("start_flag_kept", int'(volume), 15);

    // Load and htick together: the load wins.
    len_wr = 1'b1; len_idx = 5'd5; half_clk_en = 1'b1; cycle();
    check("load_beats_htick", int'(dut.length_cnt_q), 4);
    half_clk_en = 1'b1; cycle();
    check("dec_to_3", int'(dut.length_cnt_q), 3);
    rst_l = 1'b0; cycle();
    check("midreset_volume", int'(volume), 0);
    check("midreset_active", int'(length_active), 0);
    rst_l = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_l          = ($urandom_range(0, 199) != 0);
      cpu_clk_en     = ($urandom_range(0, 1) != 0);
      quarter_clk_en = ($urandom_range(0, 2) == 0);
      half_clk_en    = ($urandom_range(0, 2) == 0);
      ctrl_wr        = ($urandom_range(0, 19) == 0);
      ctrl_data      = 6'($urandom);
      len_wr         = ($urandom_range(0, 14) == 0);
      len_idx        = 5'($urandom);
      chan_en        = ($urandom_range(0, 29) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apu_envelope_length.md
APU_ENVELOPE_LENGTH -- requirements
Module: apu_envelope_length

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 clk  input  1  system clock; the only clock.
REQ-003 rst_l  input  1  reset, synchronous, active-low.
REQ-004 cpu_clk_en  input  1  CPU-rate enable; every state update is qualified by it.
REQ-005 quarter_clk_en  input  1  frame-counter quarter-frame strobe; may stay high for several clk cycles.
REQ-006 half_clk_en  input  1  frame-counter half-frame strobe; may stay high for several clk cycles.
REQ-007 ctrl_wr  input  1  channel control register write strobe.
REQ-008 ctrl_data  input  6  [5] = halt/loop, [4] = constant-volume, [3:0] = volume/envelope period.
REQ-009 len_wr  input  1  length-load register write strobe.
REQ-010 len_idx  input  5  length table index.
REQ-011 chan_en  input  1  channel enable from the status register.
REQ-012 volume  output  4  channel volume.
REQ-013 length_active  output  1  high when the length counter is nonzero.

Function
REQ-014 Qualified events: qtick = quarter_clk_en & cpu_clk_en; htick = half_clk_en & cpu_clk_en; write = wr & cpu_clk_en. Each event SHALL be counted once per cpu_clk_en cycle, not once per clk cycle.
REQ-015 A qualified ctrl_wr SHALL register halt, const_vol and period[3:0] on the next clk edge.
REQ-016 A qualified len_wr SHALL set start_flag. When chan_en = 1 it SHALL also load length_cnt[7:0] from the table below.
REQ-017 Table, idx 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
REQ-018 Envelope, on qtick:
- if start_flag = 1: clear start_flag, decay = 15, divider = period;
- else if divider = 0: divider = period, then decay-- if decay > 0, else decay = 15 if halt = 1, else hold at 0;
- else: divider--.
REQ-019 Length counter, on htick: decrement when halt = 0 and length_cnt > 0. It SHALL saturate at 0 and never wrap.
REQ-020 chan_en = 0 SHALL force length_cnt to 0 on the next clk edge, regardless of cpu_clk_en. While chan_en = 0, len_wr SHALL NOT load the counter.
REQ-021 volume = const_vol ? period : decay, subject to REQ-029 and REQ-030.
REQ-022 length_active = (length_cnt != 0). Both outputs SHALL be registered, or combinational from registered state only, with no input-to-output path.
REQ-023 Simultaneous len_wr and htick in the same cycle: the load SHALL win and no decrement SHALL occur that cycle.
REQ-024 Simultaneous len_wr and qtick in the same cycle: the qtick SHALL use the old start_flag, and the new start_flag SHALL take effect on the next qtick.
REQ-025 Simultaneous ctrl_wr and qtick or htick in the same cycle: the tick SHALL use the old halt and period, and the new values SHALL apply from the next cycle.

Reset
REQ-026 When rst_l = 0 at a clk edge, all state SHALL clear: halt, const_vol, period, start_flag, divider, decay, length_cnt = 0.
REQ-027 Reset SHALL override every other input. Reset asserted mid-envelope or mid-count SHALL discard all progress.
REQ-028 After reset: volume = 0, length_active = 0.

Configuration
REQ-029 Macro APU_LENGTH_MUTE_EN defined: volume SHALL be 0 whenever length_cnt = 0 or chan_en = 0.
REQ-030 Macro APU_LENGTH_MUTE_EN undefined: volume SHALL be the raw value of REQ-021, and muting is left to the mixer. length_active SHALL behave identically in both builds.

Verification
REQ-031 Write ctrl_data = 6'b000011 and len_wr with idx 1, chan_en = 1, then qtick -> decay = 15; afterwards decay decrements once every 4 qticks, reaches 0 and holds there; length_active = 1.
REQ-032 halt = 1 (loop), period = 0 -> decay steps 15, 14, ..., 0, 15 on successive qticks; length_cnt is unchanged across htick.
REQ-033 idx 3 (length 2), halt = 0, two htick -> length_active falls after the 2nd htick. With APU_LENGTH_MUTE_EN: volume = 0 from the next cycle.
REQ-034 quarter_clk_en held high for 5 clk cycles with cpu_clk_en pulsing once in that window -> exactly one envelope step.
REQ-035 length_cnt = 10, chan_en dropped for 1 cycle -> length_cnt = 0; len_wr while chan_en = 0 -> length stays 0, and start_flag is still set.
REQ-036 len_wr idx 5 and htick in the same cycle -> length_cnt = 4, not 3. rst_l low for 1 cycle mid-count -> all outputs 0 on the next edge.
